// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sequencer_if
//  Description : Sample / coefficient / dsp-multiplier signal bundle for
//                fir_mac_sequencer.
//                master : environment side (sample source, coefficient
//                         loader, dsp block, output stage)
//                slave  : the FIR sequencer itself
//  Signals     : sample_in[23:0], sample_valid, sample_ready,
//                coef_wr_en, coef_wr_addr[log2(NTAPS)-1:0], coef_wr_data[15:0],
//                dsp_ce, dsp_tap[15:0], dsp_signal[23:0], dsp_output[31:0],
//                out_sample[23:0], out_valid
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_mac_sequencer_if #(
    parameter int NTAPS = 16
);
    localparam int c_AW = $clog2(NTAPS);

    logic [23:0]     sample_in;
    logic            sample_valid;
    logic            sample_ready;
    logic            coef_wr_en;
    logic [c_AW-1:0] coef_wr_addr;
    logic [15:0]     coef_wr_data;
    logic            dsp_ce;
    logic [15:0]     dsp_tap;
    logic [23:0]     dsp_signal;
    logic [31:0]     dsp_output;
    logic [23:0]     out_sample;
    logic            out_valid;

    modport master (
        output sample_in, sample_valid, coef_wr_en, coef_wr_addr, coef_wr_data,
               dsp_output,
        input  sample_ready, dsp_ce, dsp_tap, dsp_signal, out_sample, out_valid
    );

    modport slave (
        input  sample_in, sample_valid, coef_wr_en, coef_wr_addr, coef_wr_data,
               dsp_output,
        output sample_ready, dsp_ce, dsp_tap, dsp_signal, out_sample, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sequencer
//  Description : Time-multiplexed FIR filter front end. Each accepted 24-bit
//                sample is written to a circular delay line, then NTAPS
//                coefficient/sample pairs are streamed into an external dsp
//                multiplier; the returned products are accumulated, scaled by
//                an arithmetic right shift and saturated to 24 bits.
//  Ports       : clk, reset (async, active high)
//                bus (slave modport of fir_mac_sequencer_if):
//                  sample_in/sample_valid/sample_ready  input sample handshake
//                  coef_wr_en/coef_wr_addr/coef_wr_data coefficient load
//                  dsp_ce/dsp_tap/dsp_signal/dsp_output multiplier interface
//                  out_sample/out_valid                 filtered output strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int NTAPS   = 16,
    parameter int DSP_LAT = 2,
    parameter int ACC_W   = 40,
    parameter int SHIFT   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_mac_sequencer_if.slave   bus
);

    localparam int c_AW = $clog2(NTAPS);
    localparam int c_CW = $clog2(NTAPS + DSP_LAT) + 1;
    localparam logic [c_CW-1:0] c_LAST_TAP   = c_CW'(NTAPS - 1);
    localparam logic [c_CW-1:0] c_LAST_DRAIN = c_CW'(DSP_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [23:0]              r_line [NTAPS];
    logic [15:0]              r_coef [NTAPS];
    logic [c_AW-1:0]          r_wp;
    logic [c_AW-1:0]          r_newest;
    logic [c_CW-1:0]          r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [15:0]              r_tap;
    logic [23:0]              r_sig;
    logic [23:0]              r_out;
    logic [DSP_LAT-1:0]       r_flag;

    logic                     w_sample_ready;
    logic                     w_dsp_ce;
    logic                     w_out_valid;
    logic                     w_accept;
    logic                     w_coef_we;
    logic                     w_issue;
    logic [15:0]              w_coef0;
    logic [c_AW-1:0]          w_next_k;
    logic [c_AW-1:0]          w_rd_idx;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [ACC_W-24:0]        w_hi;
    logic                     w_fits;
    logic [23:0]              w_sat;

    assign w_accept  = (r_state == S_IDLE) && bus.sample_valid;
    assign w_coef_we = (r_state == S_IDLE) && bus.coef_wr_en;
    assign w_issue   = (r_state == S_ISSUE);

    // A coefficient written on the accept edge must already be seen by tap 0.
    assign w_coef0 = (w_coef_we && (bus.coef_wr_addr == '0)) ? bus.coef_wr_data
                                                              : r_coef[0];

    // Pair k+1 is loaded while pair k is on the bus; the newest sample is at
    // r_newest and older ones walk backwards around the power-of-2 ring.
    assign w_next_k = r_cnt[c_AW-1:0] + c_AW'(1);
    assign w_rd_idx = r_newest - w_next_k;

    assign w_prod_ext = {{(ACC_W-32){bus.dsp_output[31]}}, bus.dsp_output};
    assign w_acc_next = r_flag[DSP_LAT-1] ? (r_acc + w_prod_ext) : r_acc;

    // Saturate when the bits above the 24-bit result are not a pure sign copy.
    assign w_shifted = w_acc_next >>> SHIFT;
    assign w_hi      = w_shifted[ACC_W-1:23];
    assign w_fits    = (&w_hi) | ~(|w_hi);
    assign w_sat     = w_fits ? w_shifted[23:0]
                              : (w_shifted[ACC_W-1] ? 24'h800000 : 24'h7FFFFF);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_sample_ready = 1'b0;
        w_dsp_ce       = 1'b0;
        w_out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sample_ready = 1'b1;
                if (bus.sample_valid) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_dsp_ce = 1'b1;
                if (r_cnt == c_LAST_TAP) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_dsp_ce = 1'b1;
                if (r_cnt == c_LAST_DRAIN) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue-flag pipeline: r_flag[DSP_LAT-1] is high exactly when
    // dsp_output carries the product of a pair issued during ISSUE.
    // ------------------------------------------------------------------
    generate
        if (DSP_LAT == 1) begin : g_flag_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_flag <= '0;
                end else begin
                    r_flag <= w_issue;
                end
            end
        end else begin : g_flag_shift
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_flag <= '0;
                end else begin
                    r_flag <= {r_flag[DSP_LAT-2:0], w_issue};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_line[i] <= '0;
                r_coef[i] <= '0;
            end
            r_wp     <= '0;
            r_newest <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_tap    <= '0;
            r_sig    <= '0;
            r_out    <= '0;
        end else begin
            if (w_coef_we) begin
                r_coef[bus.coef_wr_addr] <= bus.coef_wr_data;
            end

            r_acc <= w_acc_next;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_line[r_wp] <= bus.sample_in;
                        r_newest     <= r_wp;
                        r_wp         <= r_wp + c_AW'(1);
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        // Pair 0 bypasses the line: the new sample is only
                        // being written on this same edge.
                        r_tap        <= w_coef0;
                        r_sig        <= bus.sample_in;
                    end
                end
                S_ISSUE: begin
                    if (r_cnt == c_LAST_TAP) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                        r_tap <= r_coef[w_next_k];
                        r_sig <= r_line[w_rd_idx];
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + c_CW'(1);
                    // The final flagged product arrives in the last DRAIN
                    // cycle, so the result is taken from the next-acc value.
                    if (r_cnt == c_LAST_DRAIN) begin
                        r_out <= w_sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sample_ready = w_sample_ready;
    assign bus.dsp_ce       = w_dsp_ce;
    assign bus.dsp_tap      = r_tap;
    assign bus.dsp_signal   = r_sig;
    assign bus.out_sample   = r_out;
    assign bus.out_valid    = w_out_valid;

endmodule
`default_nettype wire
